// File: rtl/sprite_anim_ctrl_pkg.sv
// Shared definitions for the player-sprite animation controller.
//   anim_state_e : encoding driven on the anim_state output
//   dir_e        : decoded direction request
//   DEF_*        : default tile bases and frame offsets
//   dir_decode() : left/right buttons -> direction request
package sprite_anim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_SKID = 2'd2,
    ST_JUMP = 2'd3
  } anim_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_R    = 2'd1,
    DIR_L    = 2'd2
  } dir_e;

  localparam int DEF_BASE_R   = 32;
  localparam int DEF_BASE_L   = 42;
  localparam int DEF_JUMP_OFS = 4;
  localparam int DEF_SKID_OFS = 5;

  // Both or neither button held means no request at all.
  function automatic dir_e dir_decode(input logic left, input logic right);
    if (left && !right)      return DIR_L;
    else if (right && !left) return DIR_R;
    else                     return DIR_NONE;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl_anim_frame_div.sv
// Programmable frame divider for the sprite animation controller.
//   clk_walk : animation tick clock
//   rst      : asynchronous active-low reset
//   run      : selects DIV_RUN instead of DIV_WALK as the limit
//   clear    : restart the count (asserted on every FSM state change)
//   step     : combinational, high on the tick that ends a divider period
module anim_frame_div #(
  parameter int DIV_W    = 3,
  parameter int DIV_WALK = 1,
  parameter int DIV_RUN  = 0
) (
  input  logic clk_walk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic step
);

  if (DIV_WALK >= (1 << DIV_W) || DIV_RUN >= (1 << DIV_W)) begin : g_bad_lim
    $error("anim_frame_div: divider limit does not fit in DIV_W bits");
  end

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;

  assign lim = run ? DIV_W'(DIV_RUN) : DIV_W'(DIV_WALK);

  // >= rather than == so a count left above a newly selected smaller limit
  // (run pressed mid-period) steps at once instead of wrapping around.
  assign step = (cnt >= lim);

  // NOTE: reset is in the sensitivity list, so it acts without a clock edge;
  // state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_walk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Player-sprite animation controller: left/right/jump/run -> tile id.
//   clk_walk   : animation tick clock
//   rst        : asynchronous active-low reset
//   left/right : direction buttons held
//   jump       : airborne
//   run        : fast divider select
//   id         : registered tile id (base + frame/jump/skid offset)
//   oriental   : registered facing, 0 = right, 1 = left
//   walk       : registered left ^ right
//   anim_state : registered IDLE/WALK/SKID/JUMP
module sprite_anim_ctrl
  import sprite_anim_ctrl_pkg::*;
#(
  parameter int N_FRAMES = 4,
  parameter int ID_W     = 6,
  parameter int BASE_R   = DEF_BASE_R,
  parameter int BASE_L   = DEF_BASE_L,
  parameter int JUMP_OFS = DEF_JUMP_OFS,
  parameter int SKID_OFS = DEF_SKID_OFS,
  parameter int DIV_W    = 3,
  parameter int DIV_WALK = 1,
  parameter int DIV_RUN  = 0,
  parameter int SKID_LEN = 2
) (
  input  logic            clk_walk,
  input  logic            rst,
  input  logic            left,
  input  logic            right,
  input  logic            jump,
  input  logic            run,
  output logic [ID_W-1:0] id,
  output logic            oriental,
  output logic            walk,
  output logic [1:0]      anim_state
);

  localparam int FR_W    = $clog2(N_FRAMES);
  localparam int SK_W    = $clog2(SKID_LEN + 1);
  localparam int MAX_OFS = (N_FRAMES - 1 > JUMP_OFS)
                           ? ((N_FRAMES - 1 > SKID_OFS) ? N_FRAMES - 1 : SKID_OFS)
                           : ((JUMP_OFS > SKID_OFS) ? JUMP_OFS : SKID_OFS);

  if (BASE_R + MAX_OFS >= (1 << ID_W) || BASE_L + MAX_OFS >= (1 << ID_W)) begin : g_bad_id
    $error("sprite_anim_ctrl: tile ids overflow ID_W");
  end
  if (JUMP_OFS < N_FRAMES || SKID_OFS < N_FRAMES) begin : g_bad_ofs
    $error("sprite_anim_ctrl: jump/skid offsets overlap the walk cycle");
  end
  if (SKID_LEN < 1 || N_FRAMES < 2) begin : g_bad_len
    $error("sprite_anim_ctrl: SKID_LEN must be >= 1 and N_FRAMES >= 2");
  end

  localparam logic [ID_W-1:0] BASE_R_ID = ID_W'(BASE_R);
  localparam logic [ID_W-1:0] BASE_L_ID = ID_W'(BASE_L);
  localparam logic [FR_W-1:0] FRAME_MAX = FR_W'(N_FRAMES - 1);

  anim_state_e      state, state_n;
  logic             ori, ori_n;
  logic [FR_W-1:0]  frame, frame_n;
  logic [SK_W-1:0]  skid, skid_n;
  logic [ID_W-1:0]  id_n, base_n, ofs_n;
  dir_e             dir;
  logic             turn;
  logic             step;

  anim_frame_div #(
    .DIV_W   (DIV_W),
    .DIV_WALK(DIV_WALK),
    .DIV_RUN (DIV_RUN)
  ) u_div (
    .clk_walk(clk_walk),
    .rst     (rst),
    .run     (run),
    .clear   (state_n != state),
    .step    (step)
  );

  assign dir  = dir_decode(left, right);
  // A request pointing away from the current facing.
  assign turn = (dir != DIR_NONE) && ((dir == DIR_L) != ori);

  // NOTE: every combinational output gets a default first, so no path
  // through the case/if tree leaves a value held (no inferred latch).
  always_comb begin
    state_n = state;
    ori_n   = ori;
    frame_n = frame;
    skid_n  = skid;

    unique case (state)
      ST_IDLE: begin
        if (jump) begin
          state_n = ST_JUMP;
        end else if (dir != DIR_NONE) begin
          // Standing turn: face the request directly, no skid.
          ori_n   = (dir == DIR_L);
          state_n = ST_WALK;
          frame_n = FR_W'(1);
        end
      end
      ST_WALK: begin
        if (jump) begin
          state_n = ST_JUMP;
        end else if (dir == DIR_NONE) begin
          state_n = ST_IDLE;
          frame_n = '0;
        end else if (turn) begin
          ori_n   = ~ori;
          state_n = ST_SKID;
          skid_n  = SK_W'(SKID_LEN);
        end else if (step) begin
          // Walk loop skips offset 0, which is the stand frame.
          frame_n = (frame == FRAME_MAX) ? FR_W'(1) : frame + FR_W'(1);
        end
      end
      ST_SKID: begin
        if (jump) begin
          state_n = ST_JUMP;
        end else if (turn) begin
          ori_n  = ~ori;
          skid_n = SK_W'(SKID_LEN);
        end else if (step) begin
          if (skid == SK_W'(1)) begin
            // Not a turn here, so any request matches the new facing.
            if (dir != DIR_NONE) begin
              state_n = ST_WALK;
              frame_n = FR_W'(1);
            end else begin
              state_n = ST_IDLE;
              frame_n = '0;
            end
          end else begin
            skid_n = skid - SK_W'(1);
          end
        end
      end
      ST_JUMP: begin
        // Facing is frozen in the air; a held turn is taken from IDLE.
        if (!jump) begin
          state_n = ST_IDLE;
          frame_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    base_n = ori_n ? BASE_L_ID : BASE_R_ID;
    unique case (state_n)
      ST_WALK: ofs_n = ID_W'(frame_n);
      ST_SKID: ofs_n = ID_W'(SKID_OFS);
      ST_JUMP: ofs_n = ID_W'(JUMP_OFS);
      default: ofs_n = '0;
    endcase
    id_n = base_n + ofs_n;
  end

  always_ff @(posedge clk_walk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ori   <= 1'b0;
      frame <= '0;
      skid  <= '0;
      id    <= BASE_R_ID;
      walk  <= 1'b0;
    end else begin
      state <= state_n;
      ori   <= ori_n;
      frame <= frame_n;
      skid  <= skid_n;
      id    <= id_n;
      walk  <= left ^ right;
    end
  end

  assign oriental   = ori;
  assign anim_state = state;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
module tb_sprite_anim_ctrl;

  logic       clk_walk;
  logic       rst;
  logic       left, right, jump, run;
  logic [5:0] id;
  logic       oriental, walk;
  logic [1:0] anim_state;

  int n_checks = 0;
  int n_err    = 0;

  // Literal expectations for the next edge (-1 = none).
  int pin_id  = -1;
  int pin_ori = -1;

  // Behavioural model (spec constants for the default parameters).
  localparam int NF = 4, BR = 32, BL = 42, JO = 4, SO = 5;
  localparam int DWALK = 1, DRUN = 0, SLEN = 2;
  int m_state, m_ori, m_frame, m_skid, m_cnt, m_walk;

  sprite_anim_ctrl dut (
    .clk_walk  (clk_walk),
    .rst       (rst),
    .left      (left),
    .right     (right),
    .jump      (jump),
    .run       (run),
    .id        (id),
    .oriental  (oriental),
    .walk      (walk),
    .anim_state(anim_state)
  );

  initial clk_walk = 1'b0;
  always #5 clk_walk = ~clk_walk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_id();
    int ofs;
    case (m_state)
      1:       ofs = m_frame;
      2:       ofs = SO;
      3:       ofs = JO;
      default: ofs = 0;
    endcase
    return (m_ori != 0 ? BL : BR) + ofs;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ori = 0; m_frame = 0; m_skid = 0; m_cnt = 0; m_walk = 0;
  endtask

  // 0=IDLE 1=WALK 2=SKID 3=JUMP; d: 1 = left wanted, 0 = right wanted, -1 none.
  task automatic model_step(input bit l, input bit r, input bit j, input bit rn);
    int d, lim, prev;
    bit stp;
    d    = (l && !r) ? 1 : ((r && !l) ? 0 : -1);
    lim  = rn ? DRUN : DWALK;
    stp  = (m_cnt >= lim);
    prev = m_state;
    if (m_state == 3) begin
      if (!j) m_state = 0;
    end else if (j) begin
      m_state = 3;
    end else if (m_state == 0) begin
      if (d >= 0) begin m_ori = d; m_state = 1; m_frame = 1; end
    end else if (m_state == 1) begin
      if (d < 0) begin m_state = 0; m_frame = 0; end
      else if (d != m_ori) begin m_ori = d; m_state = 2; m_skid = SLEN; end
      else if (stp) m_frame = (m_frame % (NF - 1)) + 1;
    end else begin
      if (d >= 0 && d != m_ori) begin m_ori = d; m_skid = SLEN; end
      else if (stp) begin
        if (m_skid == 1) begin
          m_state = (d == m_ori) ? 1 : 0;
          m_frame = (m_state == 1) ? 1 : 0;
        end else m_skid--;
      end
    end
    m_cnt  = (m_state != prev || stp) ? 0 : m_cnt + 1;
    m_walk = l ^ r;
  endtask

  // Single compare process: model update at the edge, compare 1 time unit later.
  always @(posedge clk_walk or negedge rst) begin
    int pid, pori;
    if (!rst) begin
      model_reset();
      #1;
      check("rst_id_lit", int'(id), 32);
      check("rst_ori_lit", int'(oriental), 0);
      check("rst_walk_lit", int'(walk), 0);
      check("rst_state_lit", int'(anim_state), 0);
    end else begin
      pid  = pin_id;
      pori = pin_ori;
      model_step(left, right, jump, run);
      #1;
      check("id", int'(id), model_id());
      check("oriental", int'(oriental), m_ori);
      check("walk", int'(walk), m_walk);
      check("anim_state", int'(anim_state), m_state);
      if (pid >= 0)  check("pin_id", int'(id), pid);
      if (pori >= 0) check("pin_ori", int'(oriental), pori);
    end
  end

  task automatic drive(input bit l, input bit r, input bit j, input bit rn,
                       input int pid, input int pori);
    @(negedge clk_walk);
    left = l; right = r; jump = j; run = rn;
    pin_id = pid; pin_ori = pori;
  endtask

  task automatic pulse_reset();
    @(posedge clk_walk);
    #3;
    rst = 1'b0;
    pin_id = -1; pin_ori = -1;
    @(negedge clk_walk);
    rst = 1'b1;
  endtask

  initial begin
    int hold;
    bit l, r, j, rn;
    rst = 1'b0;
    left = 0; right = 0; jump = 0; run = 0;
    repeat (2) @(negedge clk_walk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 32, 0);

    // Walk right at walk speed: two edges per frame, wraps to 1.
    drive(0, 1, 0, 0, 33, 0); drive(0, 1, 0, 0, 33, 0);
    drive(0, 1, 0, 0, 34, 0); drive(0, 1, 0, 0, 34, 0);
    drive(0, 1, 0, 0, 35, 0); drive(0, 1, 0, 0, 35, 0);
    drive(0, 1, 0, 0, 33, 0); drive(0, 1, 0, 0, 33, 0);
    drive(0, 0, 0, 0, 32, 0);

    // Run: one frame per edge, then back to walk speed mid-sequence.
    drive(0, 1, 0, 1, 33, 0); drive(0, 1, 0, 1, 34, 0);
    drive(0, 1, 0, 1, 35, 0); drive(0, 1, 0, 1, 33, 0);
    drive(0, 1, 0, 1, 34, 0);
    drive(0, 1, 0, 0, 34, 0); drive(0, 1, 0, 0, 35, 0);
    drive(0, 1, 0, 0, 35, 0); drive(0, 1, 0, 0, 33, 0);

    // Reverse to left while walking: skid for 4 edges, then walk left.
    drive(1, 0, 0, 0, 47, 1); drive(1, 0, 0, 0, 47, 1);
    drive(1, 0, 0, 0, 47, 1); drive(1, 0, 0, 0, 47, 1);
    drive(1, 0, 0, 0, 43, 1);

    // Reverse to right, then release during the skid: ends in IDLE.
    drive(0, 1, 0, 0, 37, 0); drive(0, 0, 0, 0, 37, 0);
    drive(0, 0, 0, 0, 37, 0); drive(0, 0, 0, 0, 37, 0);
    drive(0, 0, 0, 0, 32, 0);

    // Jump: frozen facing, pending turn taken from IDLE afterwards.
    drive(0, 1, 0, 0, 33, 0); drive(0, 1, 1, 0, 36, 0);
    drive(1, 0, 1, 0, 36, 0); drive(1, 0, 0, 0, 32, 0);
    drive(1, 0, 0, 0, 43, 1);

    // Both buttons: IDLE keeps facing; then reset in the middle of a skid.
    drive(1, 1, 0, 0, 42, 1);
    drive(1, 0, 0, 0, 43, 1); drive(0, 1, 0, 0, 37, 0);
    pulse_reset();

    // Randomised phase with occasional asynchronous resets.
    for (int s = 0; s < 150; s++) begin
      l    = ($urandom_range(0, 2) == 0);
      r    = ($urandom_range(0, 2) == 0);
      j    = ($urandom_range(0, 7) == 0);
      rn   = $urandom_range(0, 1) != 0;
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) drive(l, r, j, rn, -1, -1);
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end

    drive(0, 0, 0, 0, -1, -1);
    repeat (2) @(negedge clk_walk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
